fifo_access_arbiter: RTL
========================

Name: fifo_access_arbiter

Overview:
- Shares one single-port-per-side line FIFO between N_WR producer engines (conv tiles writing partial rows) and N_RD consumer engines (MAC lanes reading rows).
- Round-robin arbitration on each side independently; one write and one read may be issued per cycle.
- Drives the FIFO select/enable/data strobes, gates requests on full/empty, and routes the FIFO's registered read data back to the winning consumer with a tag.
- Provides a flush sequence that drains the FIFO to empty between layers.

Parameters:
N_WR, 4, number of write requesters (2..8)
N_RD, 2, number of read requesters (2..8)
DATA_W, 8, FIFO data width
IDX_W, 3, width of requester index; must satisfy 2^IDX_W >= max(N_WR,N_RD)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
wr_req  in  N_WR  per-producer write request; level, held until granted
wr_data  in  N_WR*DATA_W  producer data, requester i at bits [i*DATA_W +: DATA_W]
wr_gnt  out  N_WR  one-hot write grant; the write happens this cycle
rd_req  in  N_RD  per-consumer read request; level, held until granted
rd_gnt  out  N_RD  one-hot read grant; the read strobe is issued this cycle
rd_valid  out  N_RD  one-hot; data for the consumer granted in the previous cycle is on rd_data
rd_data  out  DATA_W  read data returned to the consumer
flush  in  1  single-cycle pulse: drain the FIFO
flush_busy  out  1  high while a flush is in progress
fifo_write_sel  out  1  FIFO write select
fifo_write_en  out  1  FIFO write enable
fifo_data_in  out  DATA_W  FIFO write data
fifo_read_sel  out  1  FIFO read select
fifo_read_en  out  1  FIFO read enable
fifo_data_out  in  DATA_W  FIFO read data, registered inside the FIFO, valid one cycle after the read strobe
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag

Behaviour:
- Reset values:
  - All grants, rd_valid, flush_busy and FIFO strobes are 0.
  - fifo_data_in = 0; rd_data follows fifo_data_out (pass-through).
  - Both priority pointers are 0. State is IDLE.
- State machine: IDLE, ACTIVE, FLUSH.
  - IDLE -> ACTIVE when any wr_req or rd_req is set. ACTIVE -> IDLE when no request is set.
  - From IDLE or ACTIVE, flush=1 -> FLUSH. A flush pulse during FLUSH is ignored.
  - FLUSH -> IDLE on the first cycle fifo_empty=1 with no read in flight.
- Write arbitration (combinational from registered state):
  - Eligible only when fifo_full=0 and state != FLUSH.
  - Winner is the first requester with wr_req set, scanning from wr_ptr upward with wrap (wr_ptr, wr_ptr+1, ..., N_WR-1, 0, ...).
  - For a winner: wr_gnt[w]=1, fifo_write_sel=fifo_write_en=1, fifo_data_in = slice w.
  - On the clock edge, wr_ptr <= w+1, wrapping N_WR-1 to 0. The pointer holds if there is no grant.
- Read arbitration:
  - Same scan, using rd_ptr over rd_req.
  - Eligible only when fifo_empty=0 and state = ACTIVE; rd_gnt is never asserted in FLUSH.
  - For a winner: fifo_read_sel=fifo_read_en=1, and rd_ptr advances as above.
- Read return:
  - The winner index and a valid bit are registered (tag).
  - The next cycle, rd_valid[tag]=1 and rd_data = fifo_data_out. Latency is fixed at 1 cycle from grant.
  - Back-to-back grants produce back-to-back rd_valid.
- Flush:
  - fifo_read_sel=fifo_read_en=1 every cycle that fifo_empty=0. The returned data is discarded (rd_valid stays 0).
  - flush_busy=1 for the whole FLUSH state.
  - A rd_valid owed from a grant in the cycle before flush still fires normally.
- Simultaneous events:
  - A write and a read in the same cycle are both issued.
  - fifo_full and fifo_empty are trusted as sampled; there is no local occupancy prediction.
- Requests dropped before grant are legal. No grant is ever issued to a deasserted request.
- Asserting rst mid-operation clears any pending tag: no rd_valid appears after reset release.

Test Plan:
1. Writers 0 and 2 requesting continuously, empty FIFO, wr_ptr=0 -> grants alternate 0,2,0,2. fifo_data_in matches the granted slice each cycle.
2. Consumers 0 and 1 both request with 3 entries (0xA1,0xB2,0xC3) stored -> rd_gnt 0,1,0 on consecutive cycles. rd_valid 0,1,0 one cycle later with data A1,B2,C3. Then fifo_empty=1 blocks a further grant.
3. fifo_full=1 with all wr_req set -> no wr_gnt and no write strobe. Full drops in the same cycle a read is granted -> a write is granted the next cycle.
4. Write and read requested together with 1 entry stored -> both strobes issue in the same cycle. rd_valid follows 1 cycle later.
5. 5 entries stored, flush pulse -> flush_busy high. 5 consecutive read strobes, no rd_gnt and no rd_valid. Return to IDLE the cycle after fifo_empty=1.
6. rst asserted the cycle after a read grant -> outputs clear immediately. No rd_valid after release. Pointers restart at 0.

Source files
------------

// File: rtl/fifo_access_arbiter_if.sv
// Requester and FIFO-side signal bundle for fifo_access_arbiter.
// The arbiter takes the slave modport. Producers, consumers and the FIFO
// model take the master modport.
interface fifo_access_arbiter_if #(
    parameter int N_WR   = 4,
    parameter int N_RD   = 2,
    parameter int DATA_W = 8
);
    logic [N_WR-1:0]        wr_req;
    logic [N_WR*DATA_W-1:0] wr_data;
    logic [N_WR-1:0]        wr_gnt;
    logic [N_RD-1:0]        rd_req;
    logic [N_RD-1:0]        rd_gnt;
    logic [N_RD-1:0]        rd_valid;
    logic [DATA_W-1:0]      rd_data;
    logic                   flush;
    logic                   flush_busy;
    logic                   fifo_write_sel;
    logic                   fifo_write_en;
    logic [DATA_W-1:0]      fifo_data_in;
    logic                   fifo_read_sel;
    logic                   fifo_read_en;
    logic [DATA_W-1:0]      fifo_data_out;
    logic                   fifo_full;
    logic                   fifo_empty;

    modport master (
        output wr_req, wr_data, rd_req, flush, fifo_data_out, fifo_full, fifo_empty,
        input  wr_gnt, rd_gnt, rd_valid, rd_data, flush_busy,
               fifo_write_sel, fifo_write_en, fifo_data_in, fifo_read_sel, fifo_read_en
    );

    modport slave (
        input  wr_req, wr_data, rd_req, flush, fifo_data_out, fifo_full, fifo_empty,
        output wr_gnt, rd_gnt, rd_valid, rd_data, flush_busy,
               fifo_write_sel, fifo_write_en, fifo_data_in, fifo_read_sel, fifo_read_en
    );
endinterface

// File: rtl/fifo_access_arbiter.sv
// Round-robin write/read arbiter in front of a shared line FIFO.
// It also returns tagged read data and runs a flush sequence that drains the FIFO.
module fifo_access_arbiter #(
    parameter int N_WR   = 4,
    parameter int N_RD   = 2,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 3
) (
    input logic                 clk,
    input logic                 rst,
    fifo_access_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    localparam int REQ_PAD = 2 ** IDX_W;

    state_t           state, next_state;
    logic [IDX_W-1:0] wr_ptr, rd_ptr;
    logic [IDX_W-1:0] wr_win, rd_win;
    logic             wr_found, rd_found;
    logic             wr_issue, rd_issue;
    logic             tag_valid;
    logic [IDX_W-1:0] tag_idx;

    // Request vectors are padded to a full IDX_W index range.
    // This lets the wrapped scan index them directly.
    logic [REQ_PAD-1:0] wr_req_pad, rd_req_pad;
    logic [IDX_W:0]     wr_sum, rd_sum;

    assign wr_req_pad = REQ_PAD'(bus.wr_req);
    assign rd_req_pad = REQ_PAD'(bus.rd_req);

    // Issue conditions. Nothing is granted while reset is held.
    assign wr_issue = !rst && !bus.fifo_full && (state != FLUSH) && wr_found;
    assign rd_issue = !rst && !bus.fifo_empty && (state == ACTIVE) && rd_found;

    // Round-robin winner search starting at each side's priority pointer, with wrap
    always_comb begin
        wr_found = 1'b0;
        wr_win   = '0;
        wr_sum   = '0;
        for (int unsigned i = 0; i < N_WR; i++) begin
            wr_sum = {1'b0, wr_ptr} + (IDX_W+1)'(i);
            if (wr_sum >= (IDX_W+1)'(N_WR))
                wr_sum = wr_sum - (IDX_W+1)'(N_WR);
            if (!wr_found && wr_req_pad[wr_sum[IDX_W-1:0]]) begin
                wr_found = 1'b1;
                wr_win   = wr_sum[IDX_W-1:0];
            end
        end
        rd_found = 1'b0;
        rd_win   = '0;
        rd_sum   = '0;
        for (int unsigned i = 0; i < N_RD; i++) begin
            rd_sum = {1'b0, rd_ptr} + (IDX_W+1)'(i);
            if (rd_sum >= (IDX_W+1)'(N_RD))
                rd_sum = rd_sum - (IDX_W+1)'(N_RD);
            if (!rd_found && rd_req_pad[rd_sum[IDX_W-1:0]]) begin
                rd_found = 1'b1;
                rd_win   = rd_sum[IDX_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic. A flush pulse wins over request-driven transitions.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.flush)
                    next_state = FLUSH;
                else if ((|bus.wr_req) || (|bus.rd_req))
                    next_state = ACTIVE;
            end
            ACTIVE: begin
                if (bus.flush)
                    next_state = FLUSH;
                else if (!(|bus.wr_req) && !(|bus.rd_req))
                    next_state = IDLE;
            end
            FLUSH: begin
                if (bus.fifo_empty && !tag_valid)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output logic: grants, FIFO strobes, write data mux and read-return decode
    always_comb begin
        bus.wr_gnt         = '0;
        bus.rd_gnt         = '0;
        bus.rd_valid       = '0;
        bus.fifo_write_sel = 1'b0;
        bus.fifo_write_en  = 1'b0;
        bus.fifo_data_in   = '0;
        bus.fifo_read_sel  = 1'b0;
        bus.fifo_read_en   = 1'b0;
        bus.flush_busy     = (state == FLUSH);
        for (int unsigned i = 0; i < N_WR; i++) begin
            if (wr_issue && (wr_win == IDX_W'(i))) begin
                bus.wr_gnt[i]    = 1'b1;
                bus.fifo_data_in = bus.wr_data[i*DATA_W +: DATA_W];
            end
        end
        if (wr_issue) begin
            bus.fifo_write_sel = 1'b1;
            bus.fifo_write_en  = 1'b1;
        end
        for (int unsigned i = 0; i < N_RD; i++) begin
            if (rd_issue && (rd_win == IDX_W'(i)))
                bus.rd_gnt[i] = 1'b1;
            if (tag_valid && (tag_idx == IDX_W'(i)))
                bus.rd_valid[i] = 1'b1;
        end
        // Flush reads are untagged, so their returned data is simply dropped.
        if (rd_issue || (!rst && state == FLUSH && !bus.fifo_empty)) begin
            bus.fifo_read_sel = 1'b1;
            bus.fifo_read_en  = 1'b1;
        end
    end

    assign bus.rd_data = bus.fifo_data_out;

    // Priority pointers advance past each winner. The read tag tracks the one-cycle FIFO latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_valid <= 1'b0;
            tag_idx   <= '0;
        end else begin
            if (wr_issue)
                wr_ptr <= (wr_win == IDX_W'(N_WR-1)) ? '0 : wr_win + 1'b1;
            if (rd_issue) begin
                rd_ptr  <= (rd_win == IDX_W'(N_RD-1)) ? '0 : rd_win + 1'b1;
                tag_idx <= rd_win;
            end
            tag_valid <= rd_issue;
        end
    end

endmodule
